reg_writeback: RTL and testbench

//  - Final bexkat1 pipeline stage. Drives the register-file write port of the decode stage:
//    reg_write_o, reg_write_addr_o and reg_data_o feed decode's reg_write_i, reg_write_addr
//    and reg_data_in. bank_o is consumed by the pipeline control, not by decode.
//  - Retires one instruction per cycle from the memory stage.
//  - Waits on the data-memory acknowledge for loads, with a bounded timeout that raises a bus error.
//  - Keeps the 32-bit retired-instruction counter.

---
 rtl/bexkat1Def.sv | 25 ++
 rtl/load_format.sv | 20 ++
 rtl/reg_writeback.sv | 135 +++++++++++++
 tb/tb_reg_writeback.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bexkat1Def.sv
// Shared bexkat1 definitions: instruction types, load-width encodings and the
// writeback FSM state.
package bexkat1Def;

  localparam logic [3:0] T_INH   = 4'h0;
  localparam logic [3:0] T_ALU   = 4'h4;
  localparam logic [3:0] T_LDI   = 4'h6;
  localparam logic [3:0] T_LOAD  = 4'h7;
  localparam logic [3:0] T_STORE = 4'h8;

  localparam logic [1:0] LD_W  = 2'd0;
  localparam logic [1:0] LD_HZ = 2'd1;
  localparam logic [1:0] LD_BZ = 2'd2;
  localparam logic [1:0] LD_HS = 2'd3;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } wb_state_t;

  function automatic logic is_load(logic [31:0] ir);
    return ir[31:28] == T_LOAD;
  endfunction

endpackage

// File: rtl/load_format.sv
// Width selection and zero/sign extension of right-aligned load data.
module load_format
  import bexkat1Def::*;
(
  input  logic [1:0]  width_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    unique case (width_i)
      LD_W:  data_o = data_i;
      LD_HZ: data_o = {16'h0000, data_i[15:0]};
      LD_BZ: data_o = {24'h000000, data_i[7:0]};
      LD_HS: data_o = {{16{data_i[15]}}, data_i[15:0]};
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Final pipeline stage: retires instructions into the register-file write port,
// waits on load acknowledges with a bounded timeout, counts retired instructions.
module reg_writeback
  import bexkat1Def::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [3:0]  bank_i,
  input  logic [1:0]  reg_write_i,
  input  logic [31:0] result_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        stall_o,
  output logic [1:0]  reg_write_o,
  output logic [3:0]  reg_write_addr_o,
  output logic [31:0] reg_data_o,
  output logic [3:0]  bank_o,
  output logic        bus_err_o,
  output logic [31:0] err_pc_o,
  output logic [31:0] instret_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  wb_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      reg_write_q, reg_write_d;
  logic [3:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      bank_q, bank_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     err_pc_q, err_pc_d;
  logic [31:0]     instret_q, instret_d;

  logic        bubble, load, load_done, timeout, retire;
  logic [31:0] fmt_data;

  assign bubble = (ir_i == 64'h0);
  assign load   = is_load(ir_i[31:0]);

  load_format u_load_format (
    .width_i (ir_i[25:24]),
    .data_i  (mem_data_i),
    .data_o  (fmt_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      reg_write_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bank_q      <= '0;
      bus_err_q   <= 1'b0;
      err_pc_q    <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bank_q      <= bank_d;
      bus_err_q   <= bus_err_d;
      err_pc_q    <= err_pc_d;
      instret_q   <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_done = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          if (mem_ack_i) begin
            load_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CntW'(1);
          end
        end
      end
      S_WAIT: begin
        // An ack on the last allowed cycle takes priority over the timeout.
        if (mem_ack_i) begin
          load_done = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else if (cnt_q == CntLast) begin
          timeout = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  always_comb begin
    stall_o = !rst_i && !mem_ack_i &&
              ((state_q == S_IDLE && load) || (state_q == S_WAIT && cnt_q != CntLast));
    retire      = !bubble && (load ? load_done : (state_q == S_IDLE));
    reg_write_d = retire ? reg_write_i : 2'b00;
    addr_d      = addr_q;
    data_d      = data_q;
    bank_d      = bank_q;
    if (retire && reg_write_i != 2'b00) begin
      addr_d = ir_i[23:20];
      data_d = load ? fmt_data : result_i;
      bank_d = bank_i;
    end
    bus_err_d = timeout;
    err_pc_d  = timeout ? pc_i : err_pc_q;
    instret_d = instret_q + {31'h0, retire};
  end

  assign reg_write_o      = reg_write_q;
  assign reg_write_addr_o = addr_q;
  assign reg_data_o       = data_q;
  assign bank_o           = bank_q;
  assign bus_err_o        = bus_err_q;
  assign err_pc_o         = err_pc_q;
  assign instret_o        = instret_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed vector table, multi-cycle corner
// sequences and a randomized instruction stream against a transaction-level model.
module tb_reg_writeback;
  import bexkat1Def::*;

  localparam int T = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i;
  logic [3:0]  bank_i;
  logic [1:0]  reg_write_i;
  logic [31:0] result_i;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        stall_o;
  logic [1:0]  reg_write_o;
  logic [3:0]  reg_write_addr_o;
  logic [31:0] reg_data_o;
  logic [3:0]  bank_o;
  logic        bus_err_o;
  logic [31:0] err_pc_o;
  logic [31:0] instret_o;

  reg_writeback #(.TIMEOUT(T)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ir_i             (ir_i),
    .pc_i             (pc_i),
    .bank_i           (bank_i),
    .reg_write_i      (reg_write_i),
    .result_i         (result_i),
    .mem_ack_i        (mem_ack_i),
    .mem_data_i       (mem_data_i),
    .stall_o          (stall_o),
    .reg_write_o      (reg_write_o),
    .reg_write_addr_o (reg_write_addr_o),
    .reg_data_o       (reg_data_o),
    .bank_o           (bank_o),
    .bus_err_o        (bus_err_o),
    .err_pc_o         (err_pc_o),
    .instret_o        (instret_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected architectural view of the outputs.
  logic [1:0]  e_rw;
  logic [3:0]  e_addr;
  logic [31:0] e_data;
  logic [3:0]  e_bank;
  logic        e_err;
  logic [31:0] e_err_pc;
  logic [31:0] e_instret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    e_rw = 0; e_addr = 0; e_data = 0; e_bank = 0; e_err = 0; e_err_pc = 0; e_instret = 0;
  endtask

  task automatic check_all();
    chk("reg_write", 32'(reg_write_o), 32'(e_rw));
    chk("addr", 32'(reg_write_addr_o), 32'(e_addr));
    chk("data", reg_data_o, e_data);
    chk("bank", 32'(bank_o), 32'(e_bank));
    chk("bus_err", 32'(bus_err_o), 32'(e_err));
    chk("err_pc", err_pc_o, e_err_pc);
    chk("instret", instret_o, e_instret);
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] m, input logic [1:0] w);
    case (w)
      LD_W:    return m;
      LD_HZ:   return m & 32'h0000_FFFF;
      LD_BZ:   return m % 256;
      default: return m[15] ? (m | 32'hFFFF_0000) : (m & 32'h0000_FFFF);
    endcase
  endfunction

  function automatic logic [63:0] mk_ir(input logic [3:0] typ, input logic [1:0] w,
                                        input logic [3:0] ra);
    return {32'hA5A5_0000, typ, 2'b00, w, ra, 20'h00123};
  endfunction

  // Presents one instruction; a load sees its ack d cycles after first presentation.
  task automatic run_instr(input logic [63:0] ir, input logic [31:0] pc, input logic [3:0] bank,
                           input logic [1:0] rw, input logic [31:0] res,
                           input logic [31:0] mem, input int d);
    bit ld;
    int n;
    ld = (ir[31:28] == T_LOAD);
    n  = !ld ? 1 : ((d <= T - 1) ? d + 1 : T);
    for (int k = 0; k < n; k++) begin
      ir_i = ir; pc_i = pc; bank_i = bank; reg_write_i = rw; result_i = res;
      mem_data_i = mem; mem_ack_i = ld && (k == d);
      #1;
      chk("stall", 32'(stall_o), 32'(k < n - 1));
      @(posedge clk_i);
      #1;
      e_err = 0;
      if (k < n - 1) begin
        e_rw = 0;
      end else if (ir == 64'h0) begin
        e_rw = 0;
      end else if (ld && d > T - 1) begin
        e_rw = 0; e_err = 1; e_err_pc = pc;
      end else begin
        e_rw = rw;
        if (rw != 0) begin
          e_addr = ir[23:20];
          e_data = ld ? fmt(mem, ir[25:24]) : res;
          e_bank = bank;
        end
        e_instret = e_instret + 1;
      end
      check_all();
    end
    mem_ack_i = 0;
  endtask

  typedef struct {
    logic [3:0]  typ;
    logic [1:0]  wid;
    logic [3:0]  ra;
    logic [1:0]  rw;
    logic [31:0] result;
    logic [31:0] mem;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] held;
    vecs[0] = '{T_ALU,  LD_W,  4'd5, 2'd3, 32'hDEADBEEF, 32'h0,         32'hDEADBEEF};
    vecs[1] = '{T_LOAD, LD_BZ, 4'd2, 2'd3, 32'h0,        32'h000000F0,  32'h000000F0};
    vecs[2] = '{T_LOAD, LD_BZ, 4'd7, 2'd1, 32'h0,        32'h123456F0,  32'h000000F0};
    vecs[3] = '{T_LOAD, LD_HZ, 4'd9, 2'd3, 32'h0,        32'hABCD8001,  32'h00008001};
    vecs[4] = '{T_LOAD, LD_HS, 4'd1, 2'd3, 32'h0,        32'h00008001,  32'hFFFF8001};
    vecs[5] = '{T_LOAD, LD_HS, 4'd3, 2'd2, 32'h0,        32'h12347FFF,  32'h00007FFF};
    vecs[6] = '{T_LOAD, LD_W,  4'd15, 2'd3, 32'h0,       32'hCAFEF00D,  32'hCAFEF00D};
    vecs[7] = '{T_LDI,  LD_W,  4'd4, 2'd1, 32'h11112222, 32'h0,         32'h11112222};

    rst_i = 1; ir_i = 0; pc_i = 0; bank_i = 0; reg_write_i = 0; result_i = 0;
    mem_ack_i = 0; mem_data_i = 0;
    model_reset();
    #1;
    check_all();
    chk("stall_reset", 32'(stall_o), 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 0;

    for (int i = 0; i < 8; i++) begin
      run_instr(mk_ir(vecs[i].typ, vecs[i].wid, vecs[i].ra), 32'h100 + 32'(i * 4), 4'(i),
                vecs[i].rw, vecs[i].result, vecs[i].mem, 0);
      chk("vec_data", reg_data_o, vecs[i].exp_data);
    end

    // Halfword sign-extended load, ack three cycles late.
    run_instr(mk_ir(T_LOAD, LD_HS, 4'd6), 32'h200, 4'd2, 2'd3, 32'h0, 32'h00008001, 3);
    chk("hs_late_data", reg_data_o, 32'hFFFF8001);

    // No ack: timeout, then the error pulse must clear on the next instruction.
    held = e_instret;
    run_instr(mk_ir(T_LOAD, LD_W, 4'd8), 32'h0000_BEE0, 4'd1, 2'd3, 32'h0, 32'h5555, 1000);
    chk("timeout_err", 32'(bus_err_o), 32'h1);
    chk("timeout_instret", instret_o, held);
    run_instr(mk_ir(T_ALU, LD_W, 4'd3), 32'h300, 4'd0, 2'd3, 32'h1234, 32'h0, 0);
    chk("err_pulse_clear", 32'(bus_err_o), 32'h0);

    // Ack on the final permitted cycle wins over the timeout.
    run_instr(mk_ir(T_LOAD, LD_W, 4'd10), 32'h400, 4'd3, 2'd3, 32'h0, 32'h600DF00D, T - 1);
    chk("late_ack_data", reg_data_o, 32'h600DF00D);

    // Reset while waiting on a load.
    ir_i = mk_ir(T_LOAD, LD_W, 4'd11); pc_i = 32'h500; reg_write_i = 2'd3; mem_ack_i = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("pre_reset_stall", 32'(stall_o), 32'h1);
      @(posedge clk_i); #1;
    end
    rst_i = 1;
    #1;
    model_reset();
    check_all();
    chk("reset_stall", 32'(stall_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 0;
    run_instr(mk_ir(T_ALU, LD_W, 4'd5), 32'h600, 4'd4, 2'd3, 32'hDEADBEEF, 32'h0, 0);

    // Bubble stream.
    held = e_instret;
    for (int k = 0; k < 10; k++) run_instr(64'h0, 32'h0, 4'd0, 2'd3, 32'h9999, 32'h0, 0);
    chk("bubble_instret", instret_o, held);

    // Counter wrap.
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    e_instret = 32'hFFFF_FFFE;
    run_instr(mk_ir(T_ALU, LD_W, 4'd1), 32'h700, 4'd0, 2'd0, 32'h0, 32'h0, 0);
    run_instr(mk_ir(T_ALU, LD_W, 4'd1), 32'h704, 4'd0, 2'd1, 32'h77, 32'h0, 0);
    chk("instret_wrap", instret_o, 32'h0);

    // Randomized stream.
    for (int i = 0; i < 80; i++) begin
      int sel, d;
      logic [3:0] typ;
      logic [63:0] ir;
      sel = int'($urandom_range(0, 99));
      d   = 0;
      if (sel < 15) begin
        ir = 64'h0;
      end else begin
        if (sel < 55) begin
          typ = T_LOAD;
          d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 2, T + 3))
                                          : int'($urandom_range(0, 4));
        end else begin
          do typ = 4'($urandom); while (typ == T_LOAD);
        end
        ir = {$urandom, typ, 2'($urandom), 2'($urandom), 4'($urandom), 20'($urandom) | 20'h1};
      end
      run_instr(ir, $urandom, 4'($urandom), 2'($urandom), $urandom, $urandom, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
